// File: rtl/lcd_pkg.sv
// Shared timing defaults, pixel layout and FSM state for the LCD timing path.
// Default constants describe the 480x272 panel.
package lcd_pkg;

    localparam int DEF_H_ACTIVE = 480;
    localparam int DEF_H_FP     = 2;
    localparam int DEF_H_SYNC   = 41;
    localparam int DEF_H_BP     = 2;
    localparam int DEF_V_ACTIVE = 272;
    localparam int DEF_V_FP     = 2;
    localparam int DEF_V_SYNC   = 10;
    localparam int DEF_V_BP     = 2;

    localparam int RGB_R_HI = 15;
    localparam int RGB_R_LO = 11;
    localparam int RGB_G_HI = 10;
    localparam int RGB_G_LO = 5;
    localparam int RGB_B_HI = 4;
    localparam int RGB_B_LO = 0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } lcd_state_t;

    function automatic int lcd_total(
        input int active,
        input int fp,
        input int sync,
        input int bp
    );
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/lcd_delay_line.sv
// Fixed-depth shift register that realigns timing bits with pixel data.
// A depth of zero degenerates to a plain wire.
module lcd_delay_line #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_bypass
        logic unused;
        assign unused = ^{clk, rst};
        assign q = d;
    end else begin : g_shift
        logic [WIDTH-1:0] sr [DEPTH];

        // shift one stage per clock, flush to the idle vector on reset
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) sr[i] <= RESET_VAL;
            end else begin
                sr[0] <= d;
                for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
            end
        end

        assign q = sr[DEPTH-1];
    end

endmodule

// File: rtl/lcd_timing_gen.sv
// Parametrised LCD sync/DEN generator with look-ahead coordinates.
// Syncs and DEN are delayed to line up with the fetched RGB565 pixel.
module lcd_timing_gen
    import lcd_pkg::*;
#(
    parameter int   H_ACTIVE    = DEF_H_ACTIVE,
    parameter int   H_FP        = DEF_H_FP,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BP        = DEF_H_BP,
    parameter int   V_ACTIVE    = DEF_V_ACTIVE,
    parameter int   V_FP        = DEF_V_FP,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BP        = DEF_V_BP,
    parameter logic HSYNC_POL   = 1'b0,
    parameter logic VSYNC_POL   = 1'b0,
    parameter int   PIX_LATENCY = 2,
    parameter int   XY_W        = 10,
    parameter int   FC_W        = 8
) (
    input  logic            VGA_CLK,
    input  logic            RESET,
    input  logic            ENABLE,
    input  logic [15:0]     PIXEL_IN,
    output logic [XY_W-1:0] XPOS,
    output logic [XY_W-1:0] YPOS,
    output logic            FETCH,
    output logic            FRAME_START,
    output logic            LINE_START,
    output logic            HSYNC,
    output logic            VSYNC,
    output logic            DEN,
    output logic [4:0]      LCD_R,
    output logic [5:0]      LCD_G,
    output logic [4:0]      LCD_B,
    output logic [FC_W-1:0] FRAME_COUNT,
    output logic            BUSY
);

    localparam int H_TOTAL = lcd_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = lcd_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [XY_W-1:0] H_LAST  = XY_W'(H_TOTAL - 1);
    localparam logic [XY_W-1:0] V_LAST  = XY_W'(V_TOTAL - 1);
    localparam logic [XY_W-1:0] H_ACT   = XY_W'(H_ACTIVE);
    localparam logic [XY_W-1:0] V_ACT   = XY_W'(V_ACTIVE);
    localparam logic [XY_W-1:0] HS_BEG  = XY_W'(H_ACTIVE + H_FP);
    localparam logic [XY_W-1:0] HS_LAST = XY_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [XY_W-1:0] VS_BEG  = XY_W'(V_ACTIVE + V_FP);
    localparam logic [XY_W-1:0] VS_LAST = XY_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    lcd_state_t      state_q;
    lcd_state_t      state_d;
    logic [XY_W-1:0] h_q;
    logic [XY_W-1:0] v_q;
    logic [FC_W-1:0] fc_q;
    logic            running;
    logic            line_end;
    logic            frame_end;
    logic            hs_raw;
    logic            vs_raw;
    logic            de_raw;
    logic            hs_dl;
    logic            vs_dl;
    logic            de_dl;

    assign running   = (state_q != IDLE);
    assign line_end  = (h_q == H_LAST);
    assign frame_end = line_end && (v_q == V_LAST);

    assign de_raw = running && (h_q < H_ACT) && (v_q < V_ACT);
    assign hs_raw = running && (h_q >= HS_BEG) && (h_q <= HS_LAST);
    assign vs_raw = running && (v_q >= VS_BEG) && (v_q <= VS_LAST);

    // run/stop sequencing; stopping only takes effect on the frame's last clock
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (ENABLE) state_d = RUN;
            RUN:      if (!ENABLE) state_d = STOPPING;
            STOPPING: begin
                if (ENABLE)         state_d = RUN;
                else if (frame_end) state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge VGA_CLK) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // raster counters, parked at the origin while idle
    always_ff @(posedge VGA_CLK) begin
        if (RESET || !running) begin
            h_q <= '0;
            v_q <= '0;
        end else if (line_end) begin
            h_q <= '0;
            v_q <= (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
            h_q <= h_q + 1'b1;
        end
    end

    // completed-frame counter
    always_ff @(posedge VGA_CLK) begin
        if (RESET)                      fc_q <= '0;
        else if (running && frame_end)  fc_q <= fc_q + 1'b1;
    end

    lcd_delay_line #(
        .WIDTH     (3),
        .DEPTH     (PIX_LATENCY),
        .RESET_VAL (3'b000)
    ) u_dl (
        .clk (VGA_CLK),
        .rst (RESET),
        .d   ({hs_raw, vs_raw, de_raw}),
        .q   ({hs_dl, vs_dl, de_dl})
    );

    // panel output stage: polarity applied, colour blanked outside DEN
    always_ff @(posedge VGA_CLK) begin
        if (RESET) begin
            HSYNC <= ~HSYNC_POL;
            VSYNC <= ~VSYNC_POL;
            DEN   <= 1'b0;
            LCD_R <= '0;
            LCD_G <= '0;
            LCD_B <= '0;
        end else begin
            HSYNC <= hs_dl ? HSYNC_POL : ~HSYNC_POL;
            VSYNC <= vs_dl ? VSYNC_POL : ~VSYNC_POL;
            DEN   <= de_dl;
            LCD_R <= de_dl ? PIXEL_IN[RGB_R_HI:RGB_R_LO] : '0;
            LCD_G <= de_dl ? PIXEL_IN[RGB_G_HI:RGB_G_LO] : '0;
            LCD_B <= de_dl ? PIXEL_IN[RGB_B_HI:RGB_B_LO] : '0;
        end
    end

    assign XPOS        = h_q;
    assign YPOS        = v_q;
    assign FETCH       = de_raw;
    assign LINE_START  = running && (h_q == '0);
    assign FRAME_START = running && (h_q == '0) && (v_q == '0);
    assign FRAME_COUNT = fc_q;
    assign BUSY        = running;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: a medium raster (latency 2, active-low syncs)
// and a tiny raster (latency 0, active-high syncs, 2-bit frame count).
module tb_lcd_timing_gen;

    typedef struct packed {
        int   ha; int hf; int hs; int hb;
        int   va; int vf; int vs; int vb;
        logic hp; logic vp;
        int   fcw;
    } cfg_t;

    typedef struct packed {
        int st; int h; int v; int fc;
    } mdl_t;

    localparam cfg_t C0 = '{ha:20, hf:2, hs:5, hb:3,
                            va:10, vf:2, vs:3, vb:2,
                            hp:1'b0, vp:1'b0, fcw:8};
    localparam cfg_t C1 = '{ha:8, hf:1, hs:2, hb:1,
                            va:4, vf:1, vs:1, vb:1,
                            hp:1'b1, vp:1'b1, fcw:2};
    localparam int LAT0 = 2;
    localparam int LAT1 = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, en0, rst1, en1;
    logic [15:0] pin0, pin1;
    logic [9:0]  x0, y0;
    logic [3:0]  x1, y1;
    logic        fetch0, fs0, ls0, hs0, vs0, de0, busy0;
    logic        fetch1, fs1, ls1, hs1, vs1, de1, busy1;
    logic [4:0]  r0, b0, r1, b1;
    logic [5:0]  g0, g1;
    logic [7:0]  fc0;
    logic [1:0]  fc1;

    lcd_timing_gen #(
        .H_ACTIVE(20), .H_FP(2), .H_SYNC(5), .H_BP(3),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .PIX_LATENCY(LAT0), .XY_W(10), .FC_W(8)
    ) dut_m (
        .VGA_CLK(clk), .RESET(rst0), .ENABLE(en0), .PIXEL_IN(pin0),
        .XPOS(x0), .YPOS(y0), .FETCH(fetch0),
        .FRAME_START(fs0), .LINE_START(ls0),
        .HSYNC(hs0), .VSYNC(vs0), .DEN(de0),
        .LCD_R(r0), .LCD_G(g0), .LCD_B(b0),
        .FRAME_COUNT(fc0), .BUSY(busy0)
    );

    lcd_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
        .PIX_LATENCY(LAT1), .XY_W(4), .FC_W(2)
    ) dut_s (
        .VGA_CLK(clk), .RESET(rst1), .ENABLE(en1), .PIXEL_IN(pin1),
        .XPOS(x1), .YPOS(y1), .FETCH(fetch1),
        .FRAME_START(fs1), .LINE_START(ls1),
        .HSYNC(hs1), .VSYNC(vs1), .DEN(de1),
        .LCD_R(r1), .LCD_G(g1), .LCD_B(b1),
        .FRAME_COUNT(fc1), .BUSY(busy1)
    );

    int vectors = 0;
    int miscompares = 0;

    mdl_t m0, m1;
    logic [18:0] sb0[$], sb1[$];
    logic [15:0] pq0[$], pq1[$];
    int nfs1, nls1, k1, first_hs1;
    int gap0;
    bit watch_gap;

    function automatic logic [15:0] pix(mdl_t m);
        logic [31:0] h, v;
        h = m.h;
        v = m.v;
        return {v[4:0], h[5:0], v[4:0]};
    endfunction

    function automatic logic [18:0] idle_pins(cfg_t c);
        return {~c.hp, ~c.vp, 1'b0, 16'h0};
    endfunction

    function automatic logic [18:0] pins(cfg_t c, mdl_t m);
        bit run, hs, vs, de;
        logic [15:0] p;
        run = (m.st != 0);
        hs  = run && m.h >= c.ha + c.hf && m.h < c.ha + c.hf + c.hs;
        vs  = run && m.v >= c.va + c.vf && m.v < c.va + c.vf + c.vs;
        de  = run && m.h < c.ha && m.v < c.va;
        p   = de ? pix(m) : 16'h0;
        return {hs ? c.hp : ~c.hp, vs ? c.vp : ~c.vp, de, p};
    endfunction

    function automatic logic [31:0] ctrl(cfg_t c, mdl_t m);
        bit run, fe, ls, fs;
        logic [9:0]  hh, vv;
        logic [31:0] fc;
        run = (m.st != 0);
        fe  = run && m.h < c.ha && m.v < c.va;
        ls  = run && m.h == 0;
        fs  = ls && m.v == 0;
        hh  = 10'(m.h);
        vv  = 10'(m.v);
        fc  = m.fc % (1 << c.fcw);
        return {hh, vv, run, fe, ls, fs, fc[7:0]};
    endfunction

    function automatic mdl_t step(cfg_t c, mdl_t m, logic en, logic rst);
        mdl_t n;
        int ht, vt;
        bit last;
        n  = m;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        if (rst) begin
            n = '{st:0, h:0, v:0, fc:0};
            return n;
        end
        last = (m.h == ht - 1) && (m.v == vt - 1);
        if (m.st != 0) begin
            if (last) begin
                n.h = 0; n.v = 0; n.fc = m.fc + 1;
            end else if (m.h == ht - 1) begin
                n.h = 0; n.v = m.v + 1;
            end else begin
                n.h = m.h + 1;
            end
        end
        case (m.st)
            0:       if (en) n.st = 1;
            1:       if (!en) n.st = 2;
            default: if (en) n.st = 1; else if (last) n.st = 0;
        endcase
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        logic [18:0] e0, e1, ex0, ex1;
        mdl_t n0, n1;
        pq0.push_back(pix(m0));
        pin0 = pq0.pop_front();
        pq1.push_back(pix(m1));
        pin1 = pq1.pop_front();
        e0 = pins(C0, m0);
        e1 = pins(C1, m1);
        n0 = step(C0, m0, en0, rst0);
        n1 = step(C1, m1, en1, rst1);
        @(posedge clk);
        if (rst0) begin
            sb0.delete();
            repeat (LAT0) sb0.push_back(idle_pins(C0));
            ex0 = idle_pins(C0);
        end else begin
            sb0.push_back(e0);
            ex0 = sb0.pop_front();
        end
        if (rst1) begin
            sb1.delete();
            repeat (LAT1) sb1.push_back(idle_pins(C1));
            ex1 = idle_pins(C1);
        end else begin
            sb1.push_back(e1);
            ex1 = sb1.pop_front();
        end
        m0 = n0;
        m1 = n1;
        #1;
        chk("m_ctrl", {x0, y0, busy0, fetch0, ls0, fs0, fc0},
            ctrl(C0, m0));
        chk("m_pins", 32'({hs0, vs0, de0, r0, g0, b0}), 32'(ex0));
        chk("s_ctrl", {6'd0, x1, 6'd0, y1, busy1, fetch1, ls1, fs1,
                       6'd0, fc1}, ctrl(C1, m1));
        chk("s_pins", 32'({hs1, vs1, de1, r1, g1, b1}), 32'(ex1));
        k1++;
        if (fs1) nfs1++;
        if (ls1) nls1++;
        if (hs1 && first_hs1 < 0) first_hs1 = k1;
        if (watch_gap && !busy0) gap0++;
    endtask

    task automatic run_to0(input int h, input int v);
        int n;
        n = 0;
        while (!(m0.h == h && m0.v == v) && n < 3000) begin
            cyc();
            n++;
        end
        chk("reach_pos", 32'(m0.h == h && m0.v == v), 32'd1);
    endtask

    initial begin
        int n;
        m0 = '{st:0, h:0, v:0, fc:0};
        m1 = '{st:0, h:0, v:0, fc:0};
        repeat (LAT0) begin
            sb0.push_back(idle_pins(C0));
            pq0.push_back(16'h0);
        end
        rst0 = 1'b1; rst1 = 1'b1;
        en0  = 1'b0; en1  = 1'b0;
        pin0 = '0;   pin1 = '0;
        watch_gap = 0; gap0 = 0;
        nfs1 = 0; nls1 = 0; k1 = 0; first_hs1 = -1;

        repeat (3) cyc();
        rst0 = 1'b0; rst1 = 1'b0;
        repeat (2) cyc();

        nfs1 = 0; nls1 = 0; k1 = -1; first_hs1 = -1;
        en0 = 1'b1; en1 = 1'b1;
        cyc();
        repeat (419) cyc();
        chk("s_fs_count", nfs1, 5);
        chk("s_ls_count", nls1, 35);
        chk("s_hs_first", first_hs1, 10);
        chk("s_fc_wrap", fc1, 0);
        en1 = 1'b0;

        run_to0(0, 5);
        en0 = 1'b0;
        n = 0;
        while (busy0 && n < 2000) begin
            cyc();
            n++;
        end
        chk("m_stop_len", n, 360);
        repeat (5) cyc();
        chk("m_fc_stop", fc0, 2);

        en0 = 1'b1;
        cyc();
        run_to0(0, 3);
        en0 = 1'b0;
        repeat (20) cyc();
        en0 = 1'b1;
        watch_gap = 1;
        repeat (600) cyc();
        watch_gap = 0;
        chk("m_no_gap", gap0, 0);

        run_to0(15, 8);
        rst0 = 1'b1;
        cyc();
        chk("m_rst_pins", 32'({hs0, vs0, de0, r0, g0, b0}),
            32'({1'b1, 1'b1, 1'b0, 16'h0}));
        chk("m_rst_ctrl", {x0, y0, busy0, fs0, ls0, fetch0, fc0}, 32'd0);
        rst0 = 1'b0;
        en0  = 1'b0;
        repeat (3) cyc();
        en0 = 1'b1;
        cyc();
        chk("m_restart", {x0, y0, fs0, busy0}, {10'd0, 10'd0, 2'b11});
        repeat (100) cyc();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
